// File: rtl/mem_wb_pipe_buff.sv
// MEM/WB pipeline buffer: DEPTH falling-edge stages carrying writeback payload,
// with per-stage valid, flush, occupancy count and decode-stage hazard compare.
module mem_wb_pipe_buff #(
    parameter int unsigned WB_W   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ALU_W  = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned EPC_W  = 2,
    parameter int unsigned DEPTH  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         i_valid,
    input  logic [WB_W-1:0]              i_WB,
    input  logic [DATA_W-1:0]            i_MemData,
    input  logic [ALU_W-1:0]             i_alu,
    input  logic [REG_W-1:0]             i_Rdst,
    input  logic [DATA_W-1:0]            i_SP,
    input  logic [EPC_W-1:0]             i_changeEPC,
    input  logic [REG_W-1:0]             i_Rsrc1,
    input  logic [REG_W-1:0]             i_Rsrc2,
    output logic                         o_valid,
    output logic [WB_W-1:0]              o_WB,
    output logic [DATA_W-1:0]            o_MemData,
    output logic [ALU_W-1:0]             o_alu,
    output logic [REG_W-1:0]             o_Rdst,
    output logic [DATA_W-1:0]            o_SP,
    output logic [EPC_W-1:0]             o_changeEPC,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_hazard1,
    output logic                         o_hazard2
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] mem_data;
        logic [ALU_W-1:0]  alu;
        logic [REG_W-1:0]  rdst;
        logic [DATA_W-1:0] sp;
        logic [EPC_W-1:0]  change_epc;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_d [DEPTH];

    // Next-stage contents: flush squashes everything, enable shifts, else hold.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_d[k] = '0;
            end
        end else if (enable) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_d[k] = stage_q[k-1];
            end
            // A bubble must never write back or touch EPC.
            stage_d[0] = '{
                valid:      i_valid,
                wb:         i_valid ? i_WB : '0,
                mem_data:   i_MemData,
                alu:        i_alu,
                rdst:       i_Rdst,
                sp:         i_SP,
                change_epc: i_valid ? i_changeEPC : '0
            };
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_valid     = stage_q[DEPTH-1].valid;
    assign o_WB        = stage_q[DEPTH-1].wb;
    assign o_MemData   = stage_q[DEPTH-1].mem_data;
    assign o_alu       = stage_q[DEPTH-1].alu;
    assign o_Rdst      = stage_q[DEPTH-1].rdst;
    assign o_SP        = stage_q[DEPTH-1].sp;
    assign o_changeEPC = stage_q[DEPTH-1].change_epc;

    // Occupancy and pending-write hazards across every stage, output included.
    always_comb begin
        o_count   = '0;
        o_hazard1 = 1'b0;
        o_hazard2 = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            o_count = o_count + CNT_W'(stage_q[k].valid);
            if (stage_q[k].valid && stage_q[k].wb[0]) begin
                if (stage_q[k].rdst == i_Rsrc1) o_hazard1 = 1'b1;
                if (stage_q[k].rdst == i_Rsrc2) o_hazard2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_buff.sv
// Bench for mem_wb_pipe_buff: DEPTH 1/2/3 instances on shared inputs, checked
// against a capture-history model, a vector table and directed corner cases.
module tb_mem_wb_pipe_buff;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [31:0] mem;
        logic [15:0] alu;
        logic [2:0]  rdst;
        logic [31:0] sp;
        logic [1:0]  epc;
    } slot_t;

    typedef struct packed {
        slot_t      s;
        logic [3:0] cnt;
        logic       hz1;
        logic       hz2;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        en;
        logic        val;
        logic [1:0]  wb;
        logic [15:0] alu;
        logic [2:0]  rdst;
        logic [2:0]  rsrc1;
        logic        e_valid;
        logic [15:0] e_alu;
        logic [2:0]  e_rdst;
        logic [1:0]  e_cnt;
        logic        e_hz1;
    } vec_t;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        rst, flush, enable, i_valid;
    logic [1:0]  i_wb, i_epc;
    logic [31:0] i_mem, i_sp;
    logic [15:0] i_alu;
    logic [2:0]  i_rdst, i_rsrc1, i_rsrc2;

    logic        o_valid [3];
    logic [1:0]  o_wb    [3];
    logic [31:0] o_mem   [3];
    logic [15:0] o_alu   [3];
    logic [2:0]  o_rdst  [3];
    logic [31:0] o_sp    [3];
    logic [1:0]  o_epc   [3];
    logic        o_hz1   [3];
    logic        o_hz2   [3];
    logic [0:0]  cnt1;
    logic [1:0]  cnt2, cnt3;

    mem_wb_pipe_buff #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .i_valid(i_valid),
        .i_WB(i_wb), .i_MemData(i_mem), .i_alu(i_alu), .i_Rdst(i_rdst), .i_SP(i_sp),
        .i_changeEPC(i_epc), .i_Rsrc1(i_rsrc1), .i_Rsrc2(i_rsrc2),
        .o_valid(o_valid[0]), .o_WB(o_wb[0]), .o_MemData(o_mem[0]), .o_alu(o_alu[0]),
        .o_Rdst(o_rdst[0]), .o_SP(o_sp[0]), .o_changeEPC(o_epc[0]), .o_count(cnt1),
        .o_hazard1(o_hz1[0]), .o_hazard2(o_hz2[0]));

    mem_wb_pipe_buff #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .i_valid(i_valid),
        .i_WB(i_wb), .i_MemData(i_mem), .i_alu(i_alu), .i_Rdst(i_rdst), .i_SP(i_sp),
        .i_changeEPC(i_epc), .i_Rsrc1(i_rsrc1), .i_Rsrc2(i_rsrc2),
        .o_valid(o_valid[1]), .o_WB(o_wb[1]), .o_MemData(o_mem[1]), .o_alu(o_alu[1]),
        .o_Rdst(o_rdst[1]), .o_SP(o_sp[1]), .o_changeEPC(o_epc[1]), .o_count(cnt2),
        .o_hazard1(o_hz1[1]), .o_hazard2(o_hz2[1]));

    mem_wb_pipe_buff #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .i_valid(i_valid),
        .i_WB(i_wb), .i_MemData(i_mem), .i_alu(i_alu), .i_Rdst(i_rdst), .i_SP(i_sp),
        .i_changeEPC(i_epc), .i_Rsrc1(i_rsrc1), .i_Rsrc2(i_rsrc2),
        .o_valid(o_valid[2]), .o_WB(o_wb[2]), .o_MemData(o_mem[2]), .o_alu(o_alu[2]),
        .o_Rdst(o_rdst[2]), .o_SP(o_sp[2]), .o_changeEPC(o_epc[2]), .o_count(cnt3),
        .o_hazard1(o_hz1[2]), .o_hazard2(o_hz2[2]));

    int n_cmp = 0;
    int n_err = 0;

    // Newest capture at index 0; a squash is recorded as eight empty captures.
    slot_t hist[$];
    vec_t  tbl [9];

    function automatic obs_t get_obs(input int d);
        obs_t r;
        r.s   = '{o_valid[d], o_wb[d], o_mem[d], o_alu[d], o_rdst[d], o_sp[d], o_epc[d]};
        r.hz1 = o_hz1[d];
        r.hz2 = o_hz2[d];
        case (d)
            0:       r.cnt = 4'(cnt1);
            1:       r.cnt = 4'(cnt2);
            default: r.cnt = 4'(cnt3);
        endcase
        return r;
    endfunction

    function automatic slot_t hist_at(input int k);
        if (k < hist.size()) return hist[k];
        return '0;
    endfunction

    function automatic obs_t expected(input int d);
        obs_t  r;
        slot_t s;
        int    n = 0;
        r = '0;
        for (int k = 0; k <= d; k++) begin
            s = hist_at(k);
            if (s.valid) begin
                n++;
                if (s.wb[0] && s.rdst == i_rsrc1) r.hz1 = 1'b1;
                if (s.wb[0] && s.rdst == i_rsrc2) r.hz2 = 1'b1;
            end
        end
        r.cnt = 4'(n);
        r.s   = hist_at(d);
        if (!r.s.valid) begin
            r.s.wb  = 2'b00;
            r.s.epc = 2'b00;
        end
        return r;
    endfunction

    task automatic cmp(input int d, input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL depth%0d %s: got %0h expected %0h at %0t", d + 1, nm, a, e, $time);
        end
    endtask

    task automatic check_model();
        obs_t a, e;
        for (int d = 0; d < 3; d++) begin
            a = get_obs(d);
            e = expected(d);
            cmp(d, "valid", 64'(a.s.valid), 64'(e.s.valid));
            cmp(d, "WB",    64'(a.s.wb),    64'(e.s.wb));
            cmp(d, "Mem",   64'(a.s.mem),   64'(e.s.mem));
            cmp(d, "alu",   64'(a.s.alu),   64'(e.s.alu));
            cmp(d, "Rdst",  64'(a.s.rdst),  64'(e.s.rdst));
            cmp(d, "SP",    64'(a.s.sp),    64'(e.s.sp));
            cmp(d, "EPC",   64'(a.s.epc),   64'(e.s.epc));
            cmp(d, "count", 64'(a.cnt),     64'(e.cnt));
            cmp(d, "haz1",  64'(a.hz1),     64'(e.hz1));
            cmp(d, "haz2",  64'(a.hz2),     64'(e.hz2));
        end
    endtask

    task automatic step();
        slot_t cur;
        @(negedge clk);
        cur = '{i_valid, i_wb, i_mem, i_alu, i_rdst, i_sp, i_epc};
        if (rst || flush) begin
            for (int k = 0; k < 8; k++) hist.push_front('0);
        end else if (enable) begin
            hist.push_front(cur);
        end
        while (hist.size() > 8) void'(hist.pop_back());
        #1;
        check_model();
    endtask

    task automatic set_in(input logic v, input logic [1:0] wb, input logic [15:0] alu,
                          input logic [2:0] rdst);
        i_valid = v;
        i_wb    = wb;
        i_alu   = alu;
        i_rdst  = rdst;
        i_mem   = {16'hDEAD, alu};
        i_sp    = {16'h5000, alu ^ 16'h00FF};
        i_epc   = 2'b10;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; enable = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        obs_t a;
        rst = 1'b1; flush = 1'b0; enable = 1'b1;
        i_rsrc1 = 3'd0; i_rsrc2 = 3'd0;
        set_in(1'b1, 2'b11, 16'hFFFF, 3'd7);

        // {rst,flush,en,valid,WB,alu,Rdst,Rsrc1} -> depth-3 {valid,alu,Rdst,count,haz1}
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'hFFFF, 3'd7, 3'd7, 1'b0, 16'h0000, 3'd0, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 16'h00A5, 3'd3, 3'd3, 1'b0, 16'h0000, 3'd0, 2'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'h1111, 3'd2, 3'd3, 1'b0, 16'h0000, 3'd0, 2'd2, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 16'h2222, 3'd4, 3'd3, 1'b1, 16'h00A5, 3'd3, 2'd3, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 16'h3333, 3'd3, 3'd3, 1'b1, 16'h1111, 3'd2, 2'd2, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h4444, 3'd4, 3'd4, 1'b1, 16'h1111, 3'd2, 2'd2, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h5555, 3'd5, 3'd4, 1'b0, 16'h0000, 3'd0, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 16'h5555, 3'd5, 3'd5, 1'b0, 16'h0000, 3'd0, 2'd1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 16'h6666, 3'd6, 3'd6, 1'b0, 16'h0000, 3'd0, 2'd0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; enable = tbl[i].en;
            set_in(tbl[i].val, tbl[i].wb, tbl[i].alu, tbl[i].rdst);
            i_rsrc1 = tbl[i].rsrc1;
            step();
            a = get_obs(2);
            cmp(2, $sformatf("tbl%0d_valid", i), 64'(a.s.valid), 64'(tbl[i].e_valid));
            cmp(2, $sformatf("tbl%0d_alu", i),   64'(a.s.alu),   64'(tbl[i].e_alu));
            cmp(2, $sformatf("tbl%0d_Rdst", i),  64'(a.s.rdst),  64'(tbl[i].e_rdst));
            cmp(2, $sformatf("tbl%0d_count", i), 64'(a.cnt),     64'(tbl[i].e_cnt));
            cmp(2, $sformatf("tbl%0d_haz1", i),  64'(a.hz1),     64'(tbl[i].e_hz1));
        end

        // Stall with a full depth-2 pipe, then resume in original order.
        do_reset();
        set_in(1'b1, 2'b01, 16'h0A01, 3'd1); step();
        set_in(1'b1, 2'b01, 16'h0A02, 3'd2); step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), 2'($urandom), 16'($urandom), 3'($urandom));
            i_rsrc1 = 3'($urandom); i_rsrc2 = 3'($urandom);
            step();
            a = get_obs(1);
            cmp(1, "stall_alu",   64'(a.s.alu), 64'(16'h0A01));
            cmp(1, "stall_count", 64'(a.cnt),   64'(4'd2));
        end
        enable = 1'b1;
        set_in(1'b0, 2'b01, 16'h0BBB, 3'd3); step();
        a = get_obs(1);
        cmp(1, "resume_alu",   64'(a.s.alu),   64'(16'h0A02));
        cmp(1, "resume_valid", 64'(a.s.valid), 64'(1'b1));
        step();
        a = get_obs(1);
        cmp(1, "bubble_valid", 64'(a.s.valid), 64'(1'b0));
        cmp(1, "bubble_WB",    64'(a.s.wb),    64'(2'b00));

        // Flush with enable low squashes two in-flight writes.
        set_in(1'b1, 2'b01, 16'h0C01, 3'd6); step();
        set_in(1'b1, 2'b11, 16'h0C02, 3'd6); step();
        i_rsrc1 = 3'd6;
        flush = 1'b1; enable = 1'b0;
        step();
        flush = 1'b0; enable = 1'b1;
        a = get_obs(1);
        cmp(1, "flush_valid", 64'(a.s.valid), 64'(1'b0));
        cmp(1, "flush_WB",    64'(a.s.wb),    64'(2'b00));
        cmp(1, "flush_count", 64'(a.cnt),     64'(4'd0));
        cmp(1, "flush_haz1",  64'(a.hz1),     64'(1'b0));

        // Hazard qualification by RegWrite and valid on the depth-1 instance.
        i_rsrc1 = 3'd5; i_rsrc2 = 3'd4;
        set_in(1'b1, 2'b01, 16'h0D01, 3'd5); step();
        a = get_obs(0);
        cmp(0, "hz_hit1",  64'(a.hz1), 64'(1'b1));
        cmp(0, "hz_miss2", 64'(a.hz2), 64'(1'b0));
        set_in(1'b1, 2'b10, 16'h0D02, 3'd5); step();
        a = get_obs(0);
        cmp(0, "hz_norw1", 64'(a.hz1), 64'(1'b0));
        set_in(1'b0, 2'b01, 16'h0D03, 3'd5); step();
        a = get_obs(0);
        cmp(0, "hz_inval1", 64'(a.hz1),  64'(1'b0));
        cmp(0, "hz_invWB",  64'(a.s.wb), 64'(2'b00));
        i_rsrc2 = 3'd5;
        #1;
        check_model();

        // Randomised traffic including mid-stream reset and flush.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 19) == 0);
            enable = ($urandom_range(0, 3) != 0);
            i_valid = 1'($urandom);
            i_wb    = 2'($urandom);
            i_mem   = $urandom;
            i_alu   = 16'($urandom);
            i_rdst  = 3'($urandom);
            i_sp    = $urandom;
            i_epc   = 2'($urandom);
            i_rsrc1 = 3'($urandom);
            i_rsrc2 = 3'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
